axis_deadlock_block_detector: RTL
=================================

# axis_deadlock_block_detector

Parameterised stall detector that consumes the per-kernel AXIS port block signals and process idle/block signals gathered by the kernel deadlock monitor top and decides when the kernel is deadlocked. It sits directly downstream of the monitor top's signal gathering. Its `block` output drives the top's deadlock-path report and trigger logic. A stall is declared only after the observed signal vector has been frozen in a non-idle, blocked pattern for a programmable number of cycles.

## Interface
- `N_AXIS`, 2: number of AXIS port block inputs.
- `N_PROC`, 3: number of process idle inputs.
- `N_INST`, 1: number of process done-not-continued inputs.
- `THRESHOLD`, 16: consecutive frozen sampling edges required to assert `block`. Legal range is 2 to 2^16−1.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `axis_block_sigs`  in  N_AXIS  1 = AXIS port stalled (TDATA_blk_n low).
- `inst_idle_sigs`  in  N_PROC  1 = process idle.
- `inst_block_sigs`  in  N_INST  1 = process done but not continued.
- `block`  out  1  deadlock declared (level).
- `block_rise`  out  1  one-cycle pulse on each assertion of `block`.
- `block_axis_snap`  out  N_AXIS  value of `axis_block_sigs` captured when `block` rises.
- `block_events`  out  8  count of `block` assertions since reset, saturating at 255.

## Operation
- Sample vector V = {axis_block_sigs, inst_block_sigs, inst_idle_sigs}. Register it each edge into `v_prev`.
- Candidate C = (|axis_block_sigs or |inst_block_sigs) and not (&inst_idle_sigs).
- Stable S = (V == v_prev).
- FSM, one-hot, 3 states:
  - ST_IDLE: `cnt`←0. If C then go to ST_WATCH with `cnt`←1.
  - ST_WATCH:
    - not C → ST_IDLE.
    - C and not S → stay in ST_WATCH, `cnt`←1 (restart).
    - C and S: `cnt`←`cnt`+1. When `cnt`+1 == THRESHOLD → ST_BLOCK.
  - ST_BLOCK: `block`=1. Any of not C or not S → ST_IDLE. Otherwise hold.
- Entering ST_BLOCK:
  - `block_rise`=1 for that cycle only.
  - `block_axis_snap`←`axis_block_sigs`.
  - `block_events` increments, saturating at 255.
- `block_axis_snap` holds its value until the next rise or reset.
- `cnt` is 16 bits and never wraps, because it stops at THRESHOLD.
- Simultaneous events:
  - Vector change on the same edge that would reach THRESHOLD: the change wins. Restart at `cnt`=1, no assertion.
  - Leaving ST_BLOCK and C true with a new V on the same edge: go to ST_IDLE first. Re-qualification starts on the next edge.

## Timing
- Reset (asynchronous, low): state ST_IDLE. `cnt`, `v_prev`, `block`, `block_rise`, `block_axis_snap` and `block_events` all clear to 0.
- Release of reset is synchronous in effect. The first sampling edge is the first rising `clock` after `reset` goes high.
- Latency:
  - V candidate and constant from edge E0 onward: `block` goes high after edge E0+THRESHOLD−1, i.e. on the THRESHOLD-th edge that sees C.
  - `block_rise` is coincident with that edge.
- Deassertion: `block` goes low on the first edge that sees not C or a changed V. Latency is 1 cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset mid-operation: all outputs drop to reset values immediately, asynchronously. No `block_rise` is generated on exit.

## Structure
- Shared package `deadlock_monitor_pkg` holds:
  - state encodings ST_IDLE, ST_WATCH, ST_BLOCK;
  - `BLOCK_CNT_W` = 16;
  - `EVENT_CNT_W` = 8.
- Single module; no sub-module needed. Saturating counters are inline.

## Test plan
- THRESHOLD=4, `inst_idle_sigs`=3'b000, `axis_block_sigs`=2'b01 held from edge 1 → `block`=1 after edge 4, `block_rise` pulses once, `block_axis_snap`=2'b01, `block_events`=1.
- Same stimulus, but `axis_block_sigs` toggles to 2'b10 at edge 3 → no assertion until edge 6, then `block_axis_snap`=2'b10.
- `inst_idle_sigs`=3'b111 with `axis_block_sigs`=2'b11 held 100 cycles → `block` stays 0.
- `block` asserted, then `axis_block_sigs`→2'b00 → `block`=0 on the next edge. Re-apply 2'b01 → re-asserts after 4 edges, `block_events`=2.
- Pull `reset` low for half a cycle while in ST_BLOCK → all outputs 0 before the next edge; `block_events`=0.
- 300 assert/deassert cycles → `block_events` saturates at 255 and does not wrap.

Source files
------------

// File: rtl/deadlock_monitor_pkg.sv
// Shared definitions for the kernel deadlock monitor.
//   det_state_t   : one-hot stall-detector FSM encodings
//   BLOCK_CNT_W   : width of the frozen-vector cycle counter
//   EVENT_CNT_W   : width of the block event counter
//   sat_inc_event : saturating increment for the event counter
package deadlock_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_WATCH = 3'b010,
    ST_BLOCK = 3'b100
  } det_state_t;

  localparam int unsigned BLOCK_CNT_W = 16;
  localparam int unsigned EVENT_CNT_W = 8;

  function automatic logic [EVENT_CNT_W-1:0] sat_inc_event(
    input logic [EVENT_CNT_W-1:0] value
  );
    return (&value) ? value : value + EVENT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/axis_deadlock_block_detector.sv
// Stall detector for the kernel deadlock monitor. Declares a deadlock once the
// gathered signal vector {axis_block_sigs, inst_block_sigs, inst_idle_sigs}
// has stayed frozen in a blocked, not-all-idle pattern for THRESHOLD edges.
//
// Ports:
//   clock            sole clock, rising edge
//   reset            asynchronous active-low reset
//   axis_block_sigs  [N_AXIS] 1 = AXIS port stalled
//   inst_idle_sigs   [N_PROC] 1 = process idle
//   inst_block_sigs  [N_INST] 1 = process done but not continued
//   block            deadlock declared (level, registered)
//   block_rise       one-cycle pulse on each assertion of block
//   block_axis_snap  [N_AXIS] axis_block_sigs captured when block rises
//   block_events     [8] saturating count of block assertions since reset
module axis_deadlock_block_detector
  import deadlock_monitor_pkg::*;
#(
  parameter int unsigned N_AXIS    = 2,
  parameter int unsigned N_PROC    = 3,
  parameter int unsigned N_INST    = 1,
  parameter int unsigned THRESHOLD = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_AXIS-1:0]      axis_block_sigs,
  input  logic [N_PROC-1:0]      inst_idle_sigs,
  input  logic [N_INST-1:0]      inst_block_sigs,
  output logic                   block,
  output logic                   block_rise,
  output logic [N_AXIS-1:0]      block_axis_snap,
  output logic [EVENT_CNT_W-1:0] block_events
);

  localparam int unsigned V_W = N_AXIS + N_INST + N_PROC;
  localparam logic [BLOCK_CNT_W-1:0] THR = BLOCK_CNT_W'(THRESHOLD);

  logic [V_W-1:0]         v;
  logic [V_W-1:0]         v_prev;
  logic                   candidate;
  logic                   stable;

  det_state_t             state;
  det_state_t             state_next;
  logic [BLOCK_CNT_W-1:0] cnt;
  logic [BLOCK_CNT_W-1:0] cnt_next;
  logic [BLOCK_CNT_W-1:0] cnt_inc;
  logic                   enter_block;

  logic                   block_q;
  logic                   block_rise_q;
  logic [N_AXIS-1:0]      snap_q;
  logic [EVENT_CNT_W-1:0] events_q;

  assign v         = {axis_block_sigs, inst_block_sigs, inst_idle_sigs};
  assign candidate = ((|axis_block_sigs) || (|inst_block_sigs)) && !(&inst_idle_sigs);
  assign stable    = (v == v_prev);
  assign cnt_inc   = cnt + BLOCK_CNT_W'(1);

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    enter_block = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (candidate) begin
          state_next = ST_WATCH;
          cnt_next   = BLOCK_CNT_W'(1);
        end
      end
      ST_WATCH: begin
        if (!candidate) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (!stable) begin
          // A vector change always restarts the run, even on the edge that
          // would otherwise have reached THRESHOLD.
          cnt_next = BLOCK_CNT_W'(1);
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == THR) begin
            state_next  = ST_BLOCK;
            enter_block = 1'b1;
          end
        end
      end
      ST_BLOCK: begin
        // Exit always passes through idle; a new candidate vector is only
        // counted from the following edge.
        if (!candidate || !stable) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      v_prev <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      v_prev <= v;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      block_q      <= 1'b0;
      block_rise_q <= 1'b0;
      snap_q       <= '0;
      events_q     <= '0;
    end else begin
      block_q      <= (state_next == ST_BLOCK);
      block_rise_q <= enter_block;
      if (enter_block) begin
        snap_q   <= axis_block_sigs;
        events_q <= sat_inc_event(events_q);
      end
    end
  end

  assign block           = block_q;
  assign block_rise      = block_rise_q;
  assign block_axis_snap = snap_q;
  assign block_events    = events_q;

endmodule
